// File: rtl/seatac_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seatac_decoder
//  Purpose  : Receive-side decoder for the SeaTac runway wind-light
//             generator. It watches the 3-bit light pattern, works out which
//             wind code produced each step (previous -> current pattern),
//             flags illegal codes and illegal steps, and reports lock once
//             the decoded wind has been steady for LOCK_COUNT decodes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LOCK_COUNT    : consecutive identical decoded winds needed for lock (>=1)
//    ERR_W         : width of the saturating illegal-event counter
//  Ports
//    clk           : in  1      system clock, rising edge
//    reset_n       : in  1      asynchronous active-low reset
//    pattern       : in  3      {left,middle,right}; 100 L, 010 M, 001 R, 101 O
//    pattern_valid : in  1      sample strobe
//    clear_err     : in  1      synchronous clear of err / err_count
//    wind          : out 2      last decoded wind: 00 calm, 01 right, 10 left
//    wind_valid    : out 1      one-cycle pulse when wind was updated
//    wind_locked   : out 1      wind decoded LOCK_COUNT times in a row
//    err           : out 1      sticky illegal-event flag
//    err_count     : out ERR_W  saturating count of illegal events
//  Build option
//    SEATAC_DEC_SYNC_EN : when defined, pattern and pattern_valid each pass
//                         through a 2-flop synchronizer (reset 010 / 0)
//                         before decode, adding 2 cycles of latency.
// ============================================================================
module seatac_decoder #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       pattern,
  input  logic             pattern_valid,
  input  logic             clear_err,
  output logic [1:0]       wind,
  output logic             wind_valid,
  output logic             wind_locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  // Legal light codes
  localparam logic [2:0] PAT_L = 3'b100;
  localparam logic [2:0] PAT_M = 3'b010;
  localparam logic [2:0] PAT_R = 3'b001;
  localparam logic [2:0] PAT_O = 3'b101;

  // Decoded wind codes
  localparam logic [1:0] WIND_CALM  = 2'b00;
  localparam logic [1:0] WIND_RIGHT = 2'b01;
  localparam logic [1:0] WIND_LEFT  = 2'b10;

  // Run counter only needs to reach LOCK_COUNT
  localparam int             CNT_W    = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [2:0] smp_pat;
  logic       smp_vld;

`ifdef SEATAC_DEC_SYNC_EN
  logic [2:0] pat_s1_q;
  logic [2:0] pat_s2_q;
  logic       vld_s1_q;
  logic       vld_s2_q;

  // Synchronizer resets to the idle "middle" pattern so that the first
  // post-reset samples look like a calm runway, not an illegal code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_s1_q <= PAT_M;
      pat_s2_q <= PAT_M;
      vld_s1_q <= 1'b0;
      vld_s2_q <= 1'b0;
    end else begin
      pat_s1_q <= pattern;
      pat_s2_q <= pat_s1_q;
      vld_s1_q <= pattern_valid;
      vld_s2_q <= vld_s1_q;
    end
  end

  assign smp_pat = pat_s2_q;
  assign smp_vld = vld_s2_q;
`else
  assign smp_pat = pattern;
  assign smp_vld = pattern_valid;
`endif

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic is_legal(input logic [2:0] p);
    is_legal = (p == PAT_L) || (p == PAT_M) || (p == PAT_R) || (p == PAT_O);
  endfunction

  // Wind implied by a step between two distinct legal codes.
  function automatic logic [1:0] decode_step(input logic [2:0] prev,
                                             input logic [2:0] cur);
    decode_step = WIND_CALM;
    if (cur == PAT_O) begin
      decode_step = WIND_CALM;
    end else begin
      unique case (prev)
        PAT_O: begin
          if (cur == PAT_L)      decode_step = WIND_RIGHT;
          else if (cur == PAT_R) decode_step = WIND_LEFT;
          else                   decode_step = WIND_CALM;
        end
        PAT_M:   decode_step = (cur == PAT_L) ? WIND_RIGHT : WIND_LEFT;
        PAT_L:   decode_step = (cur == PAT_R) ? WIND_RIGHT : WIND_LEFT;
        PAT_R:   decode_step = (cur == PAT_M) ? WIND_RIGHT : WIND_LEFT;
        default: decode_step = WIND_CALM;
      endcase
    end
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [2:0]         prev_q,   prev_d;
  logic [1:0]         wind_q,   wind_d;
  logic               wv_q,     wv_d;
  logic               lock_q,   lock_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               err_q,    err_d;
  logic [ERR_W-1:0]   ecnt_q,   ecnt_d;

  logic               smp_legal;
  logic [1:0]         smp_wind;
  logic               evt;

  assign smp_legal = is_legal(smp_pat);
  assign smp_wind  = decode_step(prev_q, smp_pat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACQUIRE;
      prev_q  <= PAT_M;
      wind_q  <= WIND_CALM;
      wv_q    <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wind_q  <= wind_d;
      wv_q    <= wv_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Next-state and decode
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wind_d  = wind_q;
    wv_d    = 1'b0;
    cnt_d   = cnt_q;
    evt     = 1'b0;

    if (smp_vld) begin
      unique case (state_q)
        ST_ACQUIRE, ST_ERROR: begin
          // Any legal code (even one equal to prev) re-establishes the
          // reference without producing a decode.
          if (smp_legal) begin
            prev_d  = smp_pat;
            state_d = ST_TRACK;
          end else begin
            evt     = 1'b1;
            state_d = ST_ERROR;
          end
        end
        ST_TRACK: begin
          if (!smp_legal || (smp_pat == prev_q)) begin
            evt     = 1'b1;
            state_d = ST_ERROR;
          end else begin
            wind_d = smp_wind;
            wv_d   = 1'b1;
            prev_d = smp_pat;
            // Compare with the previous decoded wind; after an error the
            // counter is zero so the increment also yields 1.
            if (smp_wind == wind_q) begin
              if (cnt_q != LOCK_VAL) cnt_d = cnt_q + 1'b1;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end
        end
        default: state_d = ST_ACQUIRE;
      endcase
    end

    if (evt) cnt_d = '0;
  end

  assign lock_d = (state_d == ST_TRACK) && (cnt_d == LOCK_VAL);

  // Error flag/counter: an illegal event in the same cycle as clear_err
  // wins, leaving exactly one recorded event.
  always_comb begin
    err_d  = err_q;
    ecnt_d = ecnt_q;
    if (evt) begin
      err_d = 1'b1;
      if (clear_err)              ecnt_d = ERR_W'(1);
      else if (ecnt_q != ERR_MAX) ecnt_d = ecnt_q + 1'b1;
    end else if (clear_err) begin
      err_d  = 1'b0;
      ecnt_d = '0;
    end
  end

  assign wind        = wind_q;
  assign wind_valid  = wv_q;
  assign wind_locked = lock_q;
  assign err         = err_q;
  assign err_count   = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seatac_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seatac_decoder
//  Purpose  : Self-checking bench for seatac_decoder (default build):
//             table of hand-derived vectors, hand sequences for counter
//             saturation and asynchronous reset, then random samples checked
//             against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seatac_decoder;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_W      = 4;
  localparam int ERR_MAXI   = (1 << ERR_W) - 1;

  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] M = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] O = 3'b101;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       pattern = 3'b010;
  logic             pattern_valid = 1'b0;
  logic             clear_err = 1'b0;
  logic [1:0]       wind;
  logic             wind_valid;
  logic             wind_locked;
  logic             err;
  logic [ERR_W-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  seatac_decoder #(
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .clear_err     (clear_err),
    .wind          (wind),
    .wind_valid    (wind_valid),
    .wind_locked   (wind_locked),
    .err           (err),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ew, input int ewv,
                         input int elock, input int eerr, input int eec);
    chk({tag, ".wind"},        32'(wind),        32'(ew));
    chk({tag, ".wind_valid"},  32'(wind_valid),  32'(ewv));
    chk({tag, ".wind_locked"}, 32'(wind_locked), 32'(elock));
    chk({tag, ".err"},         32'(err),         32'(eerr));
    chk({tag, ".err_count"},   32'(err_count),   32'(eec));
  endtask

  // Drive one cycle of inputs and sample outputs just after the edge.
  task automatic apply(input logic [2:0] p, input bit v, input bit c);
    @(negedge clk);
    pattern       = p;
    pattern_valid = v;
    clear_err     = c;
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: lights rotate L->R->M->L for rightward wind and the
  // reverse for leftward; entering O is calm, leaving O goes to a side.
  // --------------------------------------------------------------------------
  bit         m_track;
  logic [2:0] m_prev;
  int         m_wind;
  int         m_run;
  bit         m_wv;
  bit         m_err;
  int         m_ecnt;

  function automatic bit m_legal(input logic [2:0] p);
    return (p == L) || (p == M) || (p == R) || (p == O);
  endfunction

  function automatic int m_pos(input logic [2:0] p);
    if (p == L) return 0;
    if (p == R) return 1;
    return 2;
  endfunction

  function automatic int m_decode(input logic [2:0] prev, input logic [2:0] cur);
    int d;
    if (cur == O) return 0;
    if (prev == O) return (cur == L) ? 1 : (cur == R) ? 2 : 0;
    d = (m_pos(cur) - m_pos(prev) + 3) % 3;
    return (d == 1) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_track = 0; m_prev = M; m_wind = 0; m_run = 0;
    m_wv = 0; m_err = 0; m_ecnt = 0;
  endtask

  task automatic model_step(input logic [2:0] p, input bit v, input bit c);
    bit evt;
    int d;
    evt  = 0;
    m_wv = 0;
    if (v) begin
      if (!m_track) begin
        if (m_legal(p)) begin m_prev = p; m_track = 1; end
        else evt = 1;
      end else if (!m_legal(p) || p == m_prev) begin
        evt = 1;
      end else begin
        d      = m_decode(m_prev, p);
        m_run  = (d == m_wind) ? m_run + 1 : 1;
        m_wind = d;
        m_wv   = 1;
        m_prev = p;
      end
    end
    if (evt) begin
      m_track = 0;
      m_run   = 0;
      m_err   = 1;
      m_ecnt  = c ? 1 : ((m_ecnt < ERR_MAXI) ? m_ecnt + 1 : ERR_MAXI);
    end else if (c) begin
      m_err  = 0;
      m_ecnt = 0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [2:0] pat;
    bit         vld;
    bit         clr;
    int         ew;
    int         ewv;
    int         elock;
    int         eerr;
    int         eec;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] p, input bit v, input bit c,
                              input int ew, input int ewv, input int elock,
                              input int eerr, input int eec);
    vec_t t;
    t.pat = p; t.vld = v; t.clr = c;
    t.ew = ew; t.ewv = ewv; t.elock = elock; t.eerr = eerr; t.eec = eec;
    return t;
  endfunction

  vec_t vt[$];

  initial begin
    logic [2:0] legal_tab [4];
    logic [2:0] p;
    bit         v;
    bit         c;

    legal_tab[0] = L; legal_tab[1] = M; legal_tab[2] = R; legal_tab[3] = O;

    //          pat     vld clr  wind wv lock err ecnt
    // calm generator
    vt.push_back(mk(M,      1, 0,  0,  0, 0,  0, 0));
    vt.push_back(mk(O,      1, 0,  0,  1, 0,  0, 0));
    vt.push_back(mk(M,      1, 0,  0,  1, 0,  0, 0));
    vt.push_back(mk(O,      1, 0,  0,  1, 0,  0, 0));
    vt.push_back(mk(M,      1, 0,  0,  1, 1,  0, 0));
    vt.push_back(mk(3'b111, 0, 0,  0,  0, 1,  0, 0));
    // rightward
    vt.push_back(mk(L,      1, 0,  1,  1, 0,  0, 0));
    vt.push_back(mk(R,      1, 0,  1,  1, 0,  0, 0));
    vt.push_back(mk(M,      1, 0,  1,  1, 0,  0, 0));
    vt.push_back(mk(L,      1, 0,  1,  1, 1,  0, 0));
    // leftward, then calm breaks the run
    vt.push_back(mk(M,      1, 0,  2,  1, 0,  0, 0));
    vt.push_back(mk(R,      1, 0,  2,  1, 0,  0, 0));
    vt.push_back(mk(L,      1, 0,  2,  1, 0,  0, 0));
    vt.push_back(mk(M,      1, 0,  2,  1, 1,  0, 0));
    vt.push_back(mk(O,      1, 0,  0,  1, 0,  0, 0));
    // illegal code, re-acquire, decode
    vt.push_back(mk(3'b110, 1, 0,  0,  0, 0,  1, 1));
    vt.push_back(mk(R,      1, 0,  0,  0, 0,  1, 1));
    vt.push_back(mk(L,      1, 0,  2,  1, 0,  1, 1));
    // self-step, event coinciding with clear, clear alone
    vt.push_back(mk(L,      1, 0,  2,  0, 0,  1, 2));
    vt.push_back(mk(3'b111, 1, 1,  2,  0, 0,  1, 1));
    vt.push_back(mk(3'b000, 0, 1,  2,  0, 0,  0, 0));
    // clear kept the ERROR state: M only re-acquires
    vt.push_back(mk(M,      1, 0,  2,  0, 0,  0, 0));
    vt.push_back(mk(R,      1, 0,  2,  1, 0,  0, 0));

    // Reset state
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].pat, vt[i].vld, vt[i].clr);
      chk_all($sformatf("vec%0d", i), vt[i].ew, vt[i].ewv, vt[i].elock,
              vt[i].eerr, vt[i].eec);
    end

    // Saturation of the illegal-event counter
    for (int k = 1; k <= 20; k++) begin
      apply(3'b000, 1, 0);
      chk($sformatf("sat%0d.err_count", k), 32'(err_count),
          32'((k < ERR_MAXI) ? k : ERR_MAXI));
    end
    chk("sat.err", 32'(err), 32'd1);

    // Asynchronous reset mid-stream: outputs clear before the next edge
    apply(L, 1, 0);
    apply(M, 1, 0);   // L->M leftward pulse, so wind and valid are non-zero
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    pattern_valid = 1'b0;
    reset_n = 1'b1;

    // First sample after release is acquisition only
    apply(L, 1, 0);
    chk_all("post_rst_acq", 0, 0, 0, 0, 0);
    apply(R, 1, 0);
    chk_all("post_rst_dec", 1, 1, 0, 0, 0);

    // Randomized samples against the model
    @(negedge clk);
    reset_n = 1'b0;
    pattern_valid = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 8) p = legal_tab[$urandom_range(0, 3)];
      else                          p = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      apply(p, v, c);
      model_step(p, v, c);
      chk_all($sformatf("rnd%0d", n), m_wind, int'(m_wv),
              int'(m_track && (m_run >= LOCK_COUNT)), int'(m_err), m_ecnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
